// File: rtl/secuenciador_pkg.sv
// Shared definitions for the motor start/stop sequencer.
// Contents: ESTADO width, state codes, registered-output payload struct and a
// helper that maps a state code onto the motor enables and the busy flag.
package secuenciador_pkg;

  localparam int unsigned ESTADO_W = 3;

  typedef logic [ESTADO_W-1:0] estado_t;

  localparam estado_t REPOSO    = ESTADO_W'(0);
  localparam estado_t ARRANQUE1 = ESTADO_W'(1);
  localparam estado_t MARCHA    = ESTADO_W'(2);
  localparam estado_t PARADA2   = ESTADO_W'(3);
  localparam estado_t BLOQUEO   = ESTADO_W'(4);

  // Registered drive outputs, bundled so they are updated together.
  typedef struct packed {
    logic motor1;
    logic motor2;
    logic ocupado;
  } salidas_t;

  // Motor 1 runs in every active phase; motor 2 only while both run.
  function automatic salidas_t salidas_de(input estado_t e);
    salidas_t s;
    s.motor1  = (e == ARRANQUE1) || (e == MARCHA) || (e == PARADA2);
    s.motor2  = (e == MARCHA);
    s.ocupado = (e != REPOSO);
    return s;
  endfunction

endpackage

// File: rtl/secuenciador_motores_temporizador.sv
// Loadable down-counter used to time the stagger and run phases.
// Ports: CLK, REINICIO (async active-low), carga (load strobe),
//        valor (load value), fin (count currently equals 1).
// The count saturates at 0 so it never wraps while idle.
module temporizador #(
  parameter int unsigned ANCHO = 8
) (
  input  logic             CLK,
  input  logic             REINICIO,
  input  logic             carga,
  input  logic [ANCHO-1:0] valor,
  output logic             fin
);

  logic [ANCHO-1:0] cuenta_q;
  logic [ANCHO-1:0] cuenta_d;

  // Load has precedence over the decrement.
  always_comb begin
    cuenta_d = cuenta_q;
    if (carga) begin
      cuenta_d = valor;
    end else if (cuenta_q != '0) begin
      cuenta_d = cuenta_q - ANCHO'(1);
    end
  end

  always_ff @(posedge CLK or negedge REINICIO) begin
    if (!REINICIO) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  // Expiry is flagged one count early so the FSM acts on the last cycle.
  assign fin = (cuenta_q == ANCHO'(1));

endmodule

// File: rtl/secuenciador_motores.sv
// Start/stop sequencer for two motors.
// Ports: CLK, REINICIO (async active-low), ARRANQUE (start, rising edge),
//        PARO (stop level), MODO (0 simultaneous / 1 staggered, latched at
//        start), FALLA (fault level, highest priority);
//        MOTOR1, MOTOR2 (registered enables), ESTADO (state code),
//        OCUPADO (not idle).
module secuenciador_motores
  import secuenciador_pkg::*;
#(
  parameter int unsigned RETARDO  = 4,
  parameter int unsigned T_MARCHA = 16,
  parameter int unsigned ANCHO    = 8
) (
  input  logic                CLK,
  input  logic                REINICIO,
  input  logic                ARRANQUE,
  input  logic                PARO,
  input  logic                MODO,
  input  logic                FALLA,
  output logic                MOTOR1,
  output logic                MOTOR2,
  output logic [ESTADO_W-1:0] ESTADO,
  output logic                OCUPADO
);

  estado_t          estado_q, estado_d;
  logic             modo_q, modo_d;
  logic             arr_bajo_q;
  logic             flanco_c;
  logic             carga_c;
  logic [ANCHO-1:0] valor_c;
  logic             fin_c;
  salidas_t         sal_q, sal_d;

  // Edge history holds "last sample was low"; it resets to 0 so a start
  // command already high at reset release must drop before it counts.
  always_ff @(posedge CLK or negedge REINICIO) begin
    if (!REINICIO) begin
      arr_bajo_q <= 1'b0;
    end else begin
      arr_bajo_q <= ~ARRANQUE;
    end
  end

  assign flanco_c = ARRANQUE & arr_bajo_q;

  temporizador #(
    .ANCHO (ANCHO)
  ) u_temporizador (
    .CLK      (CLK),
    .REINICIO (REINICIO),
    .carga    (carga_c),
    .valor    (valor_c),
    .fin      (fin_c)
  );

  // State register and latched mode.
  always_ff @(posedge CLK or negedge REINICIO) begin
    if (!REINICIO) begin
      estado_q <= REPOSO;
      modo_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      modo_q   <= modo_d;
    end
  end

  // Next state and timer load; priority FALLA > PARO > expiry > start edge.
  always_comb begin
    estado_d = estado_q;
    modo_d   = modo_q;
    carga_c  = 1'b0;
    valor_c  = '0;
    if (FALLA) begin
      estado_d = BLOQUEO;
    end else begin
      unique case (estado_q)
        REPOSO: begin
          if (!PARO && flanco_c) begin
            modo_d  = MODO;
            carga_c = 1'b1;
            if (MODO) begin
              estado_d = ARRANQUE1;
              valor_c  = ANCHO'(RETARDO);
            end else begin
              estado_d = MARCHA;
              valor_c  = ANCHO'(T_MARCHA);
            end
          end
        end
        ARRANQUE1: begin
          if (PARO) begin
            estado_d = REPOSO;
          end else if (fin_c) begin
            estado_d = MARCHA;
            carga_c  = 1'b1;
            valor_c  = ANCHO'(T_MARCHA);
          end
        end
        MARCHA: begin
          if (PARO || fin_c) begin
            if (modo_q) begin
              estado_d = PARADA2;
              carga_c  = 1'b1;
              valor_c  = ANCHO'(RETARDO);
            end else begin
              estado_d = REPOSO;
            end
          end
        end
        PARADA2: begin
          if (fin_c) begin
            estado_d = REPOSO;
          end
        end
        BLOQUEO: begin
          if (PARO) begin
            estado_d = REPOSO;
          end
        end
        default: begin
          estado_d = REPOSO;
        end
      endcase
    end
  end

  // Output decode from the next state so the enables track ESTADO exactly.
  always_comb begin
    sal_d = salidas_de(estado_d);
  end

  always_ff @(posedge CLK or negedge REINICIO) begin
    if (!REINICIO) begin
      sal_q <= '0;
    end else begin
      sal_q <= sal_d;
    end
  end

  assign MOTOR1  = sal_q.motor1;
  assign MOTOR2  = sal_q.motor2;
  assign OCUPADO = sal_q.ocupado;
  assign ESTADO  = estado_q;

endmodule
